// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: widths, fetch FSM states and the IF/ID bundle.
package riscv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INSN_W-1:0] instruction;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register with next-PC selection: redirect, sequential or hold.
module program_counter
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            advance_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect targets are forced onto a word boundary.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {target_i[XLEN-1:2], 2'b00};
        end else if (advance_i) begin
            pc_d = pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: drives the instruction memory, fills IF/ID, handles stall/redirect/halt.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0]   RESET_PC   = 64'd0,
    parameter logic [INSN_W-1:0] NOP_INSN   = riscv_pkg::NOP_INSN,
    parameter int unsigned       IMEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_target,
    output logic [XLEN-1:0]   address,
    input  logic [INSN_W-1:0] instruction,
    output logic [XLEN-1:0]   if_id_pc,
    output logic [INSN_W-1:0] if_id_instruction,
    output logic              if_id_valid,
    output logic              halted,
    output logic [XLEN-1:0]   fetch_count
);

    fetch_state_t    state_q;
    if_id_t          if_id_q;
    logic            halted_q;
    logic [XLEN-1:0] fetch_count_q;
    logic [XLEN-1:0] fetch_count_d;
    logic [XLEN-1:0] pc;
    logic            end_of_prog;
    logic            advance;

    assign address       = {2'b00, pc[XLEN-1:2]};
    assign end_of_prog   = (pc[XLEN-1:2] >= 62'(IMEM_DEPTH))
                        || (instruction == '0);
    assign advance       = (state_q == RUN) && !redirect
                        && !stall && !end_of_prog;
    assign fetch_count_d = fetch_count_q + 64'd1;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load_i    (redirect),
        .advance_i (advance),
        .target_i  (redirect_target),
        .pc_o      (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            if_id_q       <= '{pc: '0, instruction: NOP_INSN, valid: 1'b0};
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (redirect) begin
                        if_id_q.instruction <= NOP_INSN;
                        if_id_q.valid       <= 1'b0;
                    end else if (stall) begin
                        if_id_q <= if_id_q;
                    end else if (end_of_prog) begin
                        state_q             <= HALT;
                        halted_q            <= 1'b1;
                        if_id_q.instruction <= NOP_INSN;
                        if_id_q.valid       <= 1'b0;
                    end else begin
                        if_id_q       <= '{pc: pc, instruction: instruction, valid: 1'b1};
                        fetch_count_q <= fetch_count_d;
                    end
                end
                HALT: begin
                    // IF/ID already holds the bubble; a redirect restarts fetch.
                    if (redirect) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign if_id_pc          = if_id_q.pc;
    assign if_id_instruction = if_id_q.instruction;
    assign if_id_valid       = if_id_q.valid;
    assign halted            = halted_q;
    assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational instruction memory.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_target;
    logic [63:0] address;
    logic [31:0] instruction;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;
    logic [63:0] fetch_count;

    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    assign instruction = (address < 64'd32) ? mem[address[4:0]] : 32'h0;

    instruction_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .address           (address),
        .instruction       (instruction),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic [63:0] pc,
                             input logic [31:0] insn, input logic v,
                             input logic [63:0] cnt, input logic [63:0] addr,
                             input logic h);
        check({tag, ".pc"},    if_id_pc, pc);
        check({tag, ".insn"},  64'(if_id_instruction), 64'(insn));
        check({tag, ".valid"}, 64'(if_id_valid), 64'(v));
        check({tag, ".count"}, fetch_count, cnt);
        check({tag, ".addr"},  address, addr);
        check({tag, ".halt"},  64'(halted), 64'(h));
    endtask

    initial begin
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_0000;
        for (int i = 4; i < 32; i++) mem[i] = 32'h1000_0013 + 32'(i);

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        @(negedge clk);
        tick();
        expect_if("rst", 64'h0, NOP, 1'b0, 64'd0, 64'd0, 1'b0);
        reset = 1'b0;

        tick();
        expect_if("run0", 64'h0, 32'h0050_0093, 1'b1, 64'd1, 64'd1, 1'b0);
        tick();
        expect_if("run1", 64'h4, 32'h00A0_0113, 1'b1, 64'd2, 64'd2, 1'b0);
        tick();
        expect_if("run2", 64'h8, 32'h0020_81B3, 1'b1, 64'd3, 64'd3, 1'b0);
        tick();
        expect_if("eop", 64'h8, NOP, 1'b0, 64'd3, 64'd3, 1'b1);

        stall = 1'b1;
        tick();
        expect_if("hstall", 64'h8, NOP, 1'b0, 64'd3, 64'd3, 1'b1);
        stall = 1'b0;

        redirect = 1'b1; redirect_target = 64'h0;
        tick();
        expect_if("hredir", 64'h8, NOP, 1'b0, 64'd3, 64'd0, 1'b0);
        redirect = 1'b0;
        tick();
        expect_if("resume0", 64'h0, 32'h0050_0093, 1'b1, 64'd4, 64'd1, 1'b0);
        tick();
        expect_if("resume1", 64'h4, 32'h00A0_0113, 1'b1, 64'd5, 64'd2, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_if("stall", 64'h4, 32'h00A0_0113, 1'b1, 64'd5, 64'd2, 1'b0);
        end
        stall = 1'b0;
        tick();
        expect_if("unstall", 64'h8, 32'h0020_81B3, 1'b1, 64'd6, 64'd3, 1'b0);

        redirect = 1'b1; redirect_target = 64'h4;
        tick();
        expect_if("redir_eop", 64'h8, NOP, 1'b0, 64'd6, 64'd1, 1'b0);

        redirect_target = 64'h12;
        tick();
        expect_if("redir12", 64'h8, NOP, 1'b0, 64'd6, 64'd4, 1'b0);
        redirect = 1'b0;
        tick();
        expect_if("after12", 64'h10, 32'h1000_0017, 1'b1, 64'd7, 64'd5, 1'b0);

        redirect = 1'b1; stall = 1'b1; redirect_target = 64'h0;
        tick();
        expect_if("redir_stall", 64'h10, NOP, 1'b0, 64'd7, 64'd0, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        tick();
        expect_if("after_rs", 64'h0, 32'h0050_0093, 1'b1, 64'd8, 64'd1, 1'b0);

        redirect = 1'b1; redirect_target = 64'h80;
        tick();
        expect_if("redir80", 64'h0, NOP, 1'b0, 64'd8, 64'd32, 1'b0);
        redirect = 1'b0;
        tick();
        expect_if("oor_halt", 64'h0, NOP, 1'b0, 64'd8, 64'd32, 1'b1);

        reset = 1'b1;
        tick();
        expect_if("rst_halt", 64'h0, NOP, 1'b0, 64'd0, 64'd0, 1'b0);
        reset = 1'b0;
        tick();
        expect_if("post_rst", 64'h0, 32'h0050_0093, 1'b1, 64'd1, 64'd1, 1'b0);

        stall = 1'b1;
        tick();
        expect_if("pre_rst_stall", 64'h0, 32'h0050_0093, 1'b1, 64'd1, 64'd1, 1'b0);
        reset = 1'b1;
        tick();
        expect_if("rst_stall", 64'h0, NOP, 1'b0, 64'd0, 64'd0, 1'b0);
        reset = 1'b0; stall = 1'b0;
        tick();
        expect_if("post_rst2", 64'h0, 32'h0050_0093, 1'b1, 64'd1, 64'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the RISC-V datapath. Owns the program counter and drives the word address into the combinational instruction memory (`instruction` returned in the same cycle).
- Registers the fetched instruction and its PC into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with a single-cycle flush, and halting at end of program.
- Sits between the instruction memory and the decode stage; the other end of the memory's address/instruction interface.

Parameters:
- RESET_PC, 64'd0, byte address loaded into PC on reset.
- NOP_INSN, 32'h00000013, bubble instruction (addi x0,x0,0) written into IF/ID on flush/halt.
- IMEM_DEPTH, 32, number of 32-bit words in instruction memory; word indices >= IMEM_DEPTH are out of range.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- stall, input, 1, hazard unit request to hold PC and IF/ID.
- redirect, input, 1, taken branch/jump from EX.
- redirect_target, input, 64, byte address of the new PC.
- address, output, 64, word index into instruction memory = {2'b00, pc[63:2]}.
- instruction, input, 32, instruction word returned combinationally by memory.
- if_id_pc, output, 64, byte PC of the instruction held in IF/ID.
- if_id_instruction, output, 32, instruction held in IF/ID.
- if_id_valid, output, 1, IF/ID holds a real instruction (0 = bubble).
- halted, output, 1, fetch has stopped.
- fetch_count, output, 64, number of valid instructions delivered to IF/ID.

Behaviour:
- Reset (sampled at clk edge, overrides everything, including mid-stall or mid-halt):
  - pc=RESET_PC; state=RUN.
  - if_id_pc=0, if_id_instruction=NOP_INSN, if_id_valid=0.
  - halted=0, fetch_count=0.
- `address` is combinational from pc only; it never depends on `instruction` (no loop).
- States: RUN, HALT. `halted` = (state==HALT), registered.
- Per-edge priority in RUN: reset > redirect > stall > end-of-program check > normal.
  - redirect:
    - pc <= {redirect_target[63:2], 2'b00}; low two bits are ignored.
    - IF/ID <= bubble (NOP_INSN, valid=0, if_id_pc unchanged).
    - Stall is ignored that cycle.
    - fetch_count unchanged.
  - stall (no redirect): pc, IF/ID, fetch_count all hold.
  - end of program: pc[63:2] >= IMEM_DEPTH, or `instruction` == 32'h00000000.
    - state <= HALT; IF/ID <= bubble; pc holds; fetch_count unchanged.
  - normal:
    - if_id_pc <= pc; if_id_instruction <= instruction; if_id_valid <= 1.
    - pc <= pc + 4, 64-bit wrap-around permitted.
    - fetch_count <= fetch_count + 1, wraps at 2^64.
- HALT:
  - pc, fetch_count hold; IF/ID holds the bubble; stall ignored.
  - redirect: pc <= aligned target; state <= RUN; IF/ID stays bubble that cycle. Fetch resumes on the next edge.
- Latency: an instruction at PC p appears in IF/ID one edge after pc==p with stall=0 and redirect=0.
- Redirect penalty: exactly one bubble, from the IF/ID flush. The instruction fetched during the redirect cycle is discarded.
- Simultaneous redirect and end-of-program: redirect wins; no halt.

Decomposition:
- Shared package `riscv_pkg`:
  - NOP_INSN constant.
  - XLEN=64 and INSN_W=32.
  - fetch_state_t enum {RUN, HALT}.
  - if_id_t struct {pc, instruction, valid}, reused by the decode stage.
- One natural sub-module: `program_counter`, which holds the PC register, the next-PC mux (pc+4 / redirect / hold) and alignment. The FSM, IF/ID register and counter stay in the top.

Test Plan:
- Reset then run, memory words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x00000000:
  - address 0,1,2,3 on successive cycles.
  - IF/ID shows pc 0x0,0x4,0x8 with those words, valid=1.
  - Next edge halted=1, if_id_valid=0, fetch_count=3, address holds 3.
- stall=1 for 3 cycles at pc=0x8: address stays 2; IF/ID holds pc 0x4; fetch_count frozen. After release, word 2 enters IF/ID.
- redirect=1, target=0x12 while pc=0x4:
  - Next edge pc=0x10 (address 4), IF/ID=NOP valid=0.
  - Following edge IF/ID pc=0x10 valid=1.
- redirect and stall both high: redirect taken, stall ignored, single bubble.
- Halted, then redirect to 0x0: halted=0 after that edge, IF/ID bubble, then pc 0x0 instruction valid next edge. Also redirect to 0x80 (word 32) → halts immediately on the next fetch.
- Assert reset mid-stall and again while halted: all outputs return to reset values on that edge; first fetch from RESET_PC the edge after reset deasserts.
